// File: rtl/puf_auth_verifier_if.sv
// Host/PUF-facing signal bundle for puf_auth_verifier. The master side drives
// requests and PUF results; the slave side is the verifier itself.
interface puf_auth_verifier_if;
    logic       start;
    logic       mode;
    logic [5:0] chal_base;
    logic [5:0] puf_chal;
    logic       puf_rst;
    logic       puf_en;
    logic       puf_done;
    logic [7:0] puf_resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] hd_total;
    logic [1:0] err;

    modport master (
        output start, mode, chal_base, puf_done, puf_resp,
        input  puf_chal, puf_rst, puf_en, busy, done, pass, hd_total, err
    );
    modport slave (
        input  start, mode, chal_base, puf_done, puf_resp,
        output puf_chal, puf_rst, puf_en, busy, done, pass, hd_total, err
    );
endinterface

// File: rtl/puf_auth_verifier.sv
// Challenge-issuing PUF authentication controller: enrolls responses into a
// 64-entry table or scores them by Hamming distance. Option: PUF_AUTH_MAJORITY_EN.
module puf_auth_verifier #(
    parameter int N_CHAL  = 4,
    parameter int THRESH  = 3,
    parameter int TIMEOUT = 400_000_000
) (
    input logic               clk,
    input logic               rst_n,
    puf_auth_verifier_if.slave bus
);
    localparam int             TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT - 1);
    localparam logic [2:0]     KLAST = 3'(N_CHAL - 1);
    localparam logic [6:0]     THR   = 7'(THRESH);

    typedef enum logic [2:0] {IDLE, PRST, SETTLE, MEAS, EVAL, FIN} state_t;

    state_t        state_q;
    logic          mode_q, set_q;
    logic [2:0]    k_q;
    logic [TW-1:0] tmr_q;
    logic [7:0]    resp_q;
    logic [5:0]    chal_q;
    logic          rst_q, en_q, busy_q, done_q, pass_q;
    logic [6:0]    hd_q;
    logic [1:0]    err_q;
    logic [63:0]   vld_q;
    logic [7:0]    tbl_q [64];

    logic [7:0]    wr_d;
    logic          wr_last, wr_en;
    logic [6:0]    hd_d;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

`ifdef PUF_AUTH_MAJORITY_EN
    logic [1:0] rep_q;
    logic [7:0] m0_q, m1_q;
    assign wr_d    = (m0_q & m1_q) | (m0_q & resp_q) | (m1_q & resp_q);
    assign wr_last = (rep_q == 2'd2);
`else
    assign wr_d    = resp_q;
    assign wr_last = 1'b1;
`endif

    assign wr_en = (state_q == EVAL) && mode_q && wr_last;
    assign hd_d  = hd_q + {3'b000, popcnt8(resp_q ^ tbl_q[chal_q])};

    // Response storage carries no reset; only the valid bits matter.
    always_ff @(posedge clk) begin
        if (wr_en) tbl_q[chal_q] <= wr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            set_q   <= 1'b0;
            k_q     <= '0;
            tmr_q   <= '0;
            resp_q  <= '0;
            chal_q  <= '0;
            rst_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            hd_q    <= '0;
            err_q   <= '0;
            vld_q   <= '0;
`ifdef PUF_AUTH_MAJORITY_EN
            rep_q   <= '0;
            m0_q    <= '0;
            m1_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            rst_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    mode_q  <= bus.mode;
                    chal_q  <= bus.chal_base;
                    k_q     <= '0;
                    hd_q    <= '0;
                    pass_q  <= 1'b0;
                    err_q   <= '0;
                    rst_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= PRST;
`ifdef PUF_AUTH_MAJORITY_EN
                    rep_q   <= '0;
`endif
                end
                PRST: begin
                    set_q   <= 1'b0;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (set_q) begin
                        en_q    <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= MEAS;
                    end else begin
                        set_q <= 1'b1;
                    end
                end
                MEAS: begin
                    if (bus.puf_done) begin
                        resp_q  <= bus.puf_resp;
                        en_q    <= 1'b0;
                        state_q <= EVAL;
                    end else if (tmr_q == TMAX) begin
                        err_q   <= 2'b01;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                EVAL: begin
                    if (!mode_q && !vld_q[chal_q]) begin
                        err_q   <= 2'b10;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
`ifdef PUF_AUTH_MAJORITY_EN
                    // Enroll re-measures the same challenge until three reads are held.
                    else if (mode_q && !wr_last) begin
                        if (rep_q == 2'd0) m0_q <= resp_q;
                        else               m1_q <= resp_q;
                        rep_q   <= rep_q + 1'b1;
                        rst_q   <= 1'b1;
                        state_q <= PRST;
                    end
`endif
                    else begin
                        if (mode_q) vld_q[chal_q] <= 1'b1;
                        else        hd_q          <= hd_d;
`ifdef PUF_AUTH_MAJORITY_EN
                        rep_q <= '0;
`endif
                        if (k_q == KLAST) begin
                            pass_q  <= !mode_q && (hd_d <= THR);
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            chal_q  <= chal_q + 1'b1;
                            rst_q   <= 1'b1;
                            state_q <= PRST;
                        end
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.puf_chal = chal_q;
    assign bus.puf_rst  = rst_q;
    assign bus.puf_en   = en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.hd_total = hd_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_puf_auth_verifier.sv
// Directed bench for puf_auth_verifier: table of enroll/verify transactions
// driven through a simple PUF model, plus timeout, reset and abort sequences.
module tb_puf_auth_verifier;
`ifdef PUF_AUTH_MAJORITY_EN
    localparam int EREPS = 3;
`else
    localparam int EREPS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    puf_auth_verifier_if bus();

    puf_auth_verifier #(.N_CHAL(4), .THRESH(3), .TIMEOUT(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] rs_t [12];

    typedef struct {
        bit              md;
        logic [5:0]      base;
        logic [0:3][7:0] r;
        int              exp_nchal;
        logic [6:0]      exp_hd;
        bit              exp_pass;
        logic [1:0]      exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Issues one transaction, plays the PUF side, and checks sequencing.
    task automatic run_txn(input string nm, input bit md, input logic [5:0] base,
                           input rs_t rs, input int reps, input int maxm, output int nmeas);
        int t;
        logic [5:0] ec;
        nmeas = 0;
        bus.puf_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = md; bus.chal_base = base;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_busy"}, 32'(bus.busy), 1);
        for (int m = 0; m < maxm; m++) begin
            t = 0;
            while (!(bus.puf_rst || bus.done) && t < 40) begin @(negedge clk); t++; end
            if (bus.done) break;
            chk({nm, "_rst_seen"}, 32'(bus.puf_rst), 1);
            if (!bus.puf_rst) break;
            ec = base + 6'(m / reps);
            chk({nm, "_chal"}, 32'(bus.puf_chal), 32'(ec));
            bus.puf_done = 1'b0;
            t = 0;
            while (!bus.puf_en && t < 20) begin @(negedge clk); t++; end
            chk({nm, "_settle"}, t, 3);
            chk({nm, "_chal_hold"}, 32'(bus.puf_chal), 32'(ec));
            repeat (2) @(negedge clk);
            bus.puf_resp = rs[m];
            bus.puf_done = 1'b1;
            nmeas++;
        end
        t = 0;
        while (!bus.done && t < 40) begin @(negedge clk); t++; end
        chk({nm, "_done"}, 32'(bus.done), 1);
        // A start during FIN must be dropped.
        bus.start = 1'b1; bus.mode = ~md; bus.chal_base = 6'd33;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_done_pulse"}, 32'(bus.done), 0);
        chk({nm, "_idle"}, 32'(bus.busy), 0);
    endtask

    task automatic chk_result(input string nm, input logic [6:0] hd, input bit ps, input logic [1:0] er);
        chk({nm, "_hd"},   32'(bus.hd_total), 32'(hd));
        chk({nm, "_pass"}, 32'(bus.pass), 32'(ps));
        chk({nm, "_err"},  32'(bus.err), 32'(er));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_chal"}, 32'(bus.puf_chal), 0);
        chk({nm, "_prst"}, 32'(bus.puf_rst), 0);
        chk({nm, "_en"},   32'(bus.puf_en), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_done"}, 32'(bus.done), 0);
        chk_result(nm, 7'd0, 1'b0, 2'b00);
    endtask

    initial begin
        rs_t rs;
        int  nm, reps, t;

        // md  base  responses                       nchal hd  pass err
        vecs[0] = '{1'b1, 6'd5,  {8'hA5, 8'h3C, 8'hFF, 8'h00}, 4, 7'd0, 1'b0, 2'b00};
        vecs[1] = '{1'b0, 6'd5,  {8'hA5, 8'h3D, 8'hFE, 8'h01}, 4, 7'd3, 1'b1, 2'b00};
        vecs[2] = '{1'b0, 6'd5,  {8'hA5, 8'h3D, 8'hFE, 8'h03}, 4, 7'd4, 1'b0, 2'b00};
        vecs[3] = '{1'b0, 6'd5,  {8'hA5, 8'h3C, 8'hFF, 8'h00}, 4, 7'd0, 1'b1, 2'b00};
        vecs[4] = '{1'b1, 6'd62, {8'h11, 8'h22, 8'h33, 8'h44}, 4, 7'd0, 1'b0, 2'b00};
        vecs[5] = '{1'b0, 6'd62, {8'h11, 8'h22, 8'h33, 8'h43}, 4, 7'd3, 1'b1, 2'b00};
        vecs[6] = '{1'b0, 6'd7,  {8'hFF, 8'h01, 8'h00, 8'h00}, 3, 7'd1, 1'b0, 2'b10};

        bus.start = 1'b0; bus.mode = 1'b0; bus.chal_base = '0;
        bus.puf_done = 1'b0; bus.puf_resp = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            reps = vecs[i].md ? EREPS : 1;
            for (int m = 0; m < 12; m++) begin
                int j;
                j = m / reps;
                rs[m] = (j < 4) ? vecs[i].r[j] : 8'h00;
            end
            run_txn($sformatf("vec%0d", i), vecs[i].md, vecs[i].base, rs, reps, 4 * reps, nm);
            chk($sformatf("vec%0d_nmeas", i), nm, vecs[i].exp_nchal * reps);
            chk_result($sformatf("vec%0d", i), vecs[i].exp_hd, vecs[i].exp_pass, vecs[i].exp_err);
        end

        // Silent PUF: abort exactly TIMEOUT cycles after enable rises.
        bus.puf_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.chal_base = 6'd5;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (!bus.puf_en && t < 20) begin @(negedge clk); t++; end
        chk("to_en", 32'(bus.puf_en), 1);
        t = 0;
        while (!bus.done && t < 200) begin @(negedge clk); t++; end
        chk("to_cycles", t, 100);
        chk("to_en_off", 32'(bus.puf_en), 0);
        chk_result("to", 7'd0, 1'b0, 2'b01);
        @(negedge clk);
        chk("to_idle", 32'(bus.busy), 0);

        // Reset in the middle of a measurement.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.chal_base = 6'd30;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (!bus.puf_en && t < 20) begin @(negedge clk); t++; end
        chk("mid_en", 32'(bus.puf_en), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Valid bits are gone after reset: verify aborts on the first challenge.
        for (int m = 0; m < 12; m++) rs[m] = 8'hA5;
        run_txn("post5", 1'b0, 6'd5, rs, 1, 4, nm);
        chk("post5_nmeas", nm, 1);
        chk_result("post5", 7'd0, 1'b0, 2'b10);
        run_txn("post40", 1'b0, 6'd40, rs, 1, 4, nm);
        chk("post40_nmeas", nm, 1);
        chk_result("post40", 7'd0, 1'b0, 2'b10);

`ifdef PUF_AUTH_MAJORITY_EN
        rs = '{8'hF0, 8'hF1, 8'h70, 8'h11, 8'h11, 8'h11,
               8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33};
        run_txn("maj_enr", 1'b1, 6'd20, rs, 3, 12, nm);
        chk("maj_enr_nmeas", nm, 12);
        chk_result("maj_enr", 7'd0, 1'b0, 2'b00);
        rs = '{8'hF0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("maj_ver", 1'b0, 6'd20, rs, 1, 4, nm);
        chk("maj_ver_nmeas", nm, 4);
        chk_result("maj_ver", 7'd0, 1'b1, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/puf_auth_verifier.md
# puf_auth_verifier

Challenge-issuing authentication controller on the opposite end of the ring-oscillator PUF interface. It drives the 6-bit challenge, enable and reset into the PUF and collects its 8-bit responses. In enrollment it stores them in a 64-entry challenge-response table; in verification it scores them against that table by Hamming distance and reports pass/fail. It sits between the board control logic and the PUF core, replacing the manual switch-driven challenge entry.

## Interface
- `N_CHAL`, default 4: challenges per transaction, legal range 1..8.
- `THRESH`, default 3: maximum total Hamming distance that still passes.
- `TIMEOUT`, default 400_000_000: clock cycles allowed per PUF measurement before abort.
- `clk` input 1: global clock. One clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request. Ignored while `busy` is high.
- `mode` input 1: 1 = enroll, 0 = verify. Sampled on `start`.
- `chal_base` input 6: first challenge, sampled on `start`. Challenge k is `chal_base + k` mod 64.
- `puf_chal` output 6: challenge driven to the PUF.
- `puf_rst` output 1: active-high reset pulse to the PUF.
- `puf_en` output 1: PUF enable.
- `puf_done` input 1: PUF result valid (level).
- `puf_resp` input 8: PUF response byte.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle completion pulse.
- `pass` output 1: verify result, held until the next `start`.
- `hd_total` output 7: accumulated Hamming distance, held until the next `start`.
- `err` output 2: 00 none, 01 timeout, 10 unenrolled challenge. Held until the next `start`.

## Operation
- Storage is 64 x 8-bit response registers plus 64 valid bits. Reset clears all valid bits; data contents are don't-care.
- FSM states:
  - IDLE: on `start`, latch `mode` and `chal_base`; clear k, `hd_total`, `pass` and `err`; go to PRST.
  - PRST: `puf_rst`=1 for exactly 1 cycle; `puf_chal` is already valid; go to SETTLE.
  - SETTLE: 2 cycles with `puf_en`=0 and `puf_chal` stable; go to MEAS.
  - MEAS: `puf_en`=1. The timeout counter runs. When `puf_done`=1, sample `puf_resp` and go to EVAL. If the counter reaches `TIMEOUT`-1 with no `puf_done`, set `err`=01 and go to FIN.
  - EVAL (1 cycle), enroll: write the table at the current challenge and set its valid bit.
  - EVAL (1 cycle), verify: if the valid bit is 0, set `err`=10 and go to FIN. Otherwise add popcount(`puf_resp` ^ table entry) to `hd_total`.
  - EVAL exit: if k == `N_CHAL`-1 go to FIN; else increment k and go to PRST.
  - FIN: `done`=1 for 1 cycle. Verify sets `pass` = (`err`==00) && (`hd_total` <= `THRESH`); enroll leaves `pass`=0. Return to IDLE.
- `busy`=1 in every state except IDLE.
- `puf_en` deasserts in the cycle after `puf_done` is sampled.
- Stale `puf_done` left high from a previous measurement is never sampled, because PRST always precedes MEAS.
- Challenge wrap: `chal_base`=62 with `N_CHAL`=4 issues challenges 62, 63, 0, 1.
- Enrolling an already-valid entry overwrites it.
- `start` in the same cycle as FIN is ignored. `start` is accepted from IDLE only.
- Verify aborts on the first unenrolled challenge. `hd_total` keeps the partial sum accumulated so far.

## Timing
- Reset values: `puf_chal`=0, `puf_rst`=0, `puf_en`=0, `busy`=0, `done`=0, `pass`=0, `hd_total`=0, `err`=00, FSM in IDLE.
- `rst_n` low mid-transaction immediately forces the reset values and clears all valid bits. No `done` pulse is produced.
- Latency per challenge = 1 (PRST) + 2 (SETTLE) + PUF measurement time + 1 (EVAL) cycles.
- `done` asserts 1 cycle after the last EVAL.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- All outputs are registered.
- Hamming sum width is 7 bits. Maximum value is 8*`N_CHAL` = 64, so it never overflows.

## Configuration
- `PUF_AUTH_MAJORITY_EN` defined: in enroll mode each challenge is measured 3 times, each through its own PRST/SETTLE/MEAS pass, and the bitwise majority of the 3 responses is stored. Verify mode is unchanged. A timeout on any of the 3 passes aborts the transaction.
- `PUF_AUTH_MAJORITY_EN` undefined: one measurement per challenge in all modes. No majority registers are generated.

## Test plan
- Enroll `chal_base`=5, PUF model returns 0xA5, 0x3C, 0xFF, 0x00 → one `done` pulse, `err`=00, `pass`=0, table entries 5..8 valid.
- Verify `chal_base`=5 with responses 0xA5, 0x3D, 0xFE, 0x01 → `hd_total`=3, `pass`=1. Repeat with last response 0x03 → `hd_total`=4, `pass`=0.
- Verify `chal_base`=40 after reset → `err`=10 after the first EVAL, `pass`=0, `hd_total`=0.
- `chal_base`=62, enroll → `puf_chal` sequence 62, 63, 0, 1, each preceded by a 1-cycle `puf_rst` pulse and 2 settle cycles.
- `TIMEOUT`=100 with a PUF model that never raises `puf_done` → `err`=01 and `done` exactly 100 cycles after `puf_en` rises; `rst_n` pulsed mid-MEAS → all outputs return to reset values, `busy`=0.
- With `PUF_AUTH_MAJORITY_EN` defined, enroll with three reads 0xF0, 0xF1, 0x70 → stored 0xF0; a subsequent verify returning 0xF0 → `hd_total` contribution 0.
